seg7_scan_display: RTL

- Downstream consumer of the 4-bit BCD countdown digit and its sibling digit sources.
- Drives the BASYS2 4-digit common-anode seven-segment display by time-multiplexing four BCD digits.
- Provides per-digit enable, invalid-code indication and a whole-display blink request used when the countdown expires.
- Registered outputs connect directly to board pins.

---
 rtl/seg7_scan_display_if.sv | 21 ++
 rtl/seg7_scan_display.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_display_if.sv
// Pin-side bundle for the BASYS2 seven-segment scanner: digit sources in, board pins out.
`timescale 1ns/1ps
interface seg7_scan_display_if;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic        blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output digits, digit_en, dp_in, blink,
    input  an, seg, dp
  );

  modport slave (
    input  digits, digit_en, dp_in, blink,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with blink; all state on negedge clk.
// Optional leading-zero suppression: define SEG7_LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module seg7_scan_display #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_scan_display_if.slave   bus
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_e;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  phase_e             phase_q, phase_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic [3:0] nib;
  logic [6:0] dec;
  logic [3:0] blank;
  logic       visible;
  logic       show;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= PH_ON;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  // Blink timing restarts from the visible phase whenever blink is low.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = PH_ON;
    if (bus.blink) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Walk from digit3 down; a disabled higher digit does not stop suppression.
  always_comb begin
    logic higher_clear;
    logic [3:0] n;
    higher_clear = 1'b1;
    blank        = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      n                = bus.digits[(3 - i) * 4 +: 4];
      blank[3 - i]     = higher_clear && (n == 4'd0);
      higher_clear     = higher_clear && ((n == 4'd0) || !bus.digit_en[3 - i]);
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    nib = bus.digits[{idx_q, 2'b00} +: 4];
    unique case (nib)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  end

  always_comb begin
    visible = !(bus.blink && (phase_q == PH_OFF));
    show    = visible && bus.digit_en[idx_q] && !blank[idx_q];
    an_d    = show ? ~(4'b0001 << idx_q) : '1;
    seg_d   = visible ? dec : '1;
    dp_d    = show ? ~bus.dp_in[idx_q] : 1'b1;
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
